// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_pkg: lamp encoding and detector state types shared with      |
// | traffic_signal.                                                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } signal_e;

  localparam logic [1:0] c_sig_illegal = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAITING = 2'b01,
    REQUEST = 2'b10,
    SERVING = 2'b11
  } det_state_e;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sensor_debounce: 2-flop synchronizer, level debounce and one-cycle   |
// | arrival pulse on the debounced rising edge.                          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_raw,
  output logic deb_level,
  output logic arrival
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] c_cnt_last = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= sensor_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // The level flips on the DEB_CYCLES-th consecutive disagreeing sample.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign deb_level = r_level;
  assign arrival   = r_level & ~r_level_d;

endmodule : sensor_debounce
`default_nettype wire

// File: rtl/traffic_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_detector: loop-sensor conditioning, stop-line queue tracking |
// | and request generation for traffic_signal.                           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module traffic_detector
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int CNT_W        = 4,
  parameter int REQ_THRESH   = 3,
  parameter int WAIT_MAX     = 20,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_raw,
  input  logic [1:0]       signal,
  output logic             traffic,
  output logic [CNT_W-1:0] queue_count,
  output logic             overflow,
  output logic             fault
);

  localparam int TMR_W = $clog2(WAIT_MAX + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_max_q     = '1;
  localparam logic [CNT_W-1:0] c_thresh    = CNT_W'(REQ_THRESH);
  localparam logic [TMR_W-1:0] c_wait_last = TMR_W'(WAIT_MAX - 1);
  localparam logic [DRN_W-1:0] c_drn_last  = DRN_W'(DRAIN_CYCLES - 1);

  logic             w_deb_level;
  logic             w_arrival;
  logic             w_green;
  logic             w_illegal;
  logic             w_inc;
  logic             w_dec;
  logic             w_q_empty;
  logic [CNT_W-1:0] w_q_next;
  det_state_e       r_state;
  det_state_e       w_state_next;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_next;
  logic [DRN_W-1:0] r_drain;
  logic [DRN_W-1:0] w_drain_next;
  logic [CNT_W-1:0] r_queue;
  logic             r_overflow;
  logic             r_fault;
  logic             r_traffic;

  sensor_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sensor_debounce (
    .clk        (clk),
    .rst        (rst),
    .sensor_raw (sensor_raw),
    .deb_level  (w_deb_level),
    .arrival    (w_arrival)
  );

  assign w_green   = (signal == GREEN);
  assign w_illegal = (signal == c_sig_illegal);
  assign w_q_empty = (r_queue == '0);
  // Vehicles crossing during GREEN pass straight through and are not queued.
  assign w_inc     = w_arrival & w_deb_level & ~w_green;
  assign w_dec     = w_green & ~w_q_empty & (r_drain == c_drn_last);

  always_comb begin
    w_q_next = r_queue;
    if (w_inc) begin
      if (r_queue != c_max_q) w_q_next = r_queue + 1'b1;
    end else if (w_dec) begin
      w_q_next = r_queue - 1'b1;
    end
  end

  always_comb begin
    w_drain_next = r_drain;
    if (!w_illegal) begin
      if (!w_green || w_q_empty || w_dec) w_drain_next = '0;
      else                                w_drain_next = r_drain + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    if (!w_illegal) begin
      case (r_state)
        // A non-empty queue in IDLE covers arrivals counted while frozen.
        IDLE: begin
          if (w_inc || !w_q_empty) begin
            w_state_next = WAITING;
            w_timer_next = '0;
          end
        end
        WAITING: begin
          w_timer_next = r_timer + 1'b1;
          if (w_green)                                        w_state_next = SERVING;
          else if (r_queue >= c_thresh || r_timer == c_wait_last) w_state_next = REQUEST;
        end
        REQUEST: begin
          if (w_green) w_state_next = SERVING;
        end
        SERVING: begin
          if (w_q_empty) begin
            w_state_next = IDLE;
          end else if (!w_green) begin
            w_state_next = WAITING;
            w_timer_next = '0;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_drain    <= '0;
      r_queue    <= '0;
      r_overflow <= 1'b0;
      r_fault    <= 1'b0;
      r_traffic  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_drain   <= w_drain_next;
      r_queue   <= w_q_next;
      r_fault   <= w_illegal;
      r_traffic <= (w_state_next == REQUEST) || (w_state_next == SERVING) || w_illegal;
      if (w_q_next == '0)                 r_overflow <= 1'b0;
      else if (w_inc && r_queue == c_max_q) r_overflow <= 1'b1;
    end
  end

  assign traffic     = r_traffic;
  assign queue_count = r_queue;
  assign overflow    = r_overflow;
  assign fault       = r_fault;

endmodule : traffic_detector
`default_nettype wire

// File: tb/tb_traffic_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_traffic_detector: directed vector tables plus hand sequences for  |
// | saturation, fault freeze and asynchronous reset.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_traffic_detector;
  import traffic_pkg::*;

  logic       clk;
  logic       rst;
  logic       sensor_raw;
  logic [1:0] signal;
  logic       traffic;
  logic [3:0] queue_count;
  logic       overflow;
  logic       fault;

  int n_cmp = 0;
  int n_err = 0;

  traffic_detector #(
    .DEB_CYCLES   (4),
    .CNT_W        (4),
    .REQ_THRESH   (3),
    .WAIT_MAX     (20),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_raw  (sensor_raw),
    .signal      (signal),
    .traffic     (traffic),
    .queue_count (queue_count),
    .overflow    (overflow),
    .fault       (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       sensor;
    logic [1:0] sig;
    int         cycles;
    logic       exp_traffic;
    logic [3:0] exp_q;
    logic       exp_ovf;
    logic       exp_fault;
  } vec_t;

  vec_t vec[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic t, input logic [3:0] q,
                           input logic o, input logic f);
    check({name, ".traffic"},  32'(traffic),     32'(t));
    check({name, ".queue"},    32'(queue_count), 32'(q));
    check({name, ".overflow"}, 32'(overflow),    32'(o));
    check({name, ".fault"},    32'(fault),       32'(f));
  endtask

  // Leaves the bench 1 ns after the release edge; the next edge is edge 1.
  task automatic do_reset(input logic s);
    sensor_raw = s;
    signal     = RED;
    rst        = 1'b1;
    #2;
    check_all("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic add(input logic s, input logic [1:0] g, input int n, input logic t,
                     input int q, input logic o, input logic f);
    vec_t v;
    v.sensor      = s;
    v.sig         = g;
    v.cycles      = n;
    v.exp_traffic = t;
    v.exp_q       = 4'(q);
    v.exp_ovf     = o;
    v.exp_fault   = f;
    vec.push_back(v);
  endtask

  task automatic run_vec(input string tag);
    for (int i = 0; i < vec.size(); i++) begin
      sensor_raw = vec[i].sensor;
      signal     = vec[i].sig;
      repeat (vec[i].cycles) tick();
      check_all($sformatf("%s[%0d]", tag, i), vec[i].exp_traffic, vec[i].exp_q,
                vec[i].exp_ovf, vec[i].exp_fault);
    end
    vec.delete();
  endtask

  task automatic pulse(input int hi, input int lo);
    sensor_raw = 1'b1;
    repeat (hi) tick();
    sensor_raw = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    rst        = 1'b1;
    sensor_raw = 1'b0;
    signal     = RED;

    // Single arrival, then forced request after 20 cycles of waiting.
    do_reset(1'b0);
    add(1, RED, 6,  0, 0, 0, 0);
    add(1, RED, 1,  0, 1, 0, 0);
    add(1, RED, 3,  0, 1, 0, 0);
    add(0, RED, 16, 0, 1, 0, 0);
    add(0, RED, 1,  1, 1, 0, 0);
    run_vec("single");

    // Glitches of 1..3 cycles are rejected.
    do_reset(1'b0);
    add(1, RED, 1, 0, 0, 0, 0);
    add(0, RED, 6, 0, 0, 0, 0);
    add(1, RED, 2, 0, 0, 0, 0);
    add(0, RED, 6, 0, 0, 0, 0);
    add(1, RED, 3, 0, 0, 0, 0);
    add(0, RED, 8, 0, 0, 0, 0);
    run_vec("glitch");

    // Three arrivals raise the request; GREEN drains two cycles per vehicle.
    do_reset(1'b0);
    add(1, RED,   4, 0, 0, 0, 0);
    add(0, RED,   3, 0, 1, 0, 0);
    add(0, RED,   1, 0, 1, 0, 0);
    add(1, RED,   4, 0, 1, 0, 0);
    add(0, RED,   3, 0, 2, 0, 0);
    add(0, RED,   1, 0, 2, 0, 0);
    add(1, RED,   4, 0, 2, 0, 0);
    add(0, RED,   3, 0, 3, 0, 0);
    add(0, RED,   1, 1, 3, 0, 0);
    add(0, GREEN, 1, 1, 3, 0, 0);
    add(0, GREEN, 1, 1, 2, 0, 0);
    add(0, GREEN, 2, 1, 1, 0, 0);
    add(0, GREEN, 2, 1, 0, 0, 0);
    add(0, GREEN, 1, 0, 0, 0, 0);
    run_vec("drain");

    // Illegal lamp code mid-WAITING freezes the wait timer by 5 cycles.
    do_reset(1'b0);
    add(1, RED,           4,  0, 0, 0, 0);
    add(0, RED,           3,  0, 1, 0, 0);
    add(0, RED,           3,  0, 1, 0, 0);
    add(0, c_sig_illegal, 1,  1, 1, 0, 1);
    add(0, c_sig_illegal, 4,  1, 1, 0, 1);
    add(0, RED,           1,  0, 1, 0, 0);
    add(0, RED,           15, 0, 1, 0, 0);
    add(0, RED,           1,  1, 1, 0, 0);
    run_vec("fault");

    // Saturation at 15 with sticky overflow, cleared when drained to 0.
    do_reset(1'b0);
    repeat (16) pulse(4, 4);
    check_all("sat.full", 1'b1, 4'd15, 1'b1, 1'b0);
    signal = GREEN;
    repeat (29) tick();
    check_all("sat.last", 1'b1, 4'd1, 1'b1, 1'b0);
    tick();
    check_all("sat.empty", 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    check_all("sat.idle", 1'b0, 4'd0, 1'b0, 1'b0);

    // Sensor already high at reset release counts as one arrival.
    do_reset(1'b1);
    repeat (6) tick();
    check("relhi.edge6", 32'(queue_count), 32'd0);
    tick();
    check("relhi.edge7", 32'(queue_count), 32'd1);

    // Asynchronous reset while SERVING with 5 queued.
    do_reset(1'b0);
    repeat (5) pulse(4, 4);
    check_all("srv.queued", 1'b1, 4'd5, 1'b0, 1'b0);
    signal = GREEN;
    tick();
    check_all("srv.serving", 1'b1, 4'd5, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check_all("srv.async_rst", 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_traffic_detector
`default_nettype wire
